// File: rtl/master_write_control_pkg.sv
// Shared TPU controller package: default array geometry and the
// count-minus-one row/column encoding used by reader and writer FSMs.
package master_write_control_pkg;

  localparam int unsigned TPU_ADDR_WIDTH   = 8;
  localparam int unsigned TPU_WIDTH_HEIGHT = 16;

  // num_row/num_col hold count-1, so the final diagonal step of an
  // (nr+1) x (nc+1) tile is simply their sum.
  function automatic int unsigned last_step(
    input int unsigned nr,
    input int unsigned nc
  );
    return nr + nc;
  endfunction

endpackage

// File: rtl/master_write_control_write_lane.sv
// One output lane: decides whether lane LANE writes at step t and
// forms its address base + (t - LANE); idle lanes drive address 0.
module write_lane
  import master_write_control_pkg::*;
#(
  parameter int LANE       = 0,
  parameter int addr_width = 8,
  parameter int cnt_width  = 4
) (
  input  logic                  en,
  input  logic [cnt_width:0]    t,
  input  logic [cnt_width-1:0]  num_row,
  input  logic [cnt_width-1:0]  num_col,
  input  logic [addr_width-1:0] base_addr,
  output logic                  wr_en,
  output logic [addr_width-1:0] wr_addr
);

  localparam int TW = cnt_width + 1;
  localparam logic [TW-1:0] LANE_T = TW'(LANE);

  logic [TW-1:0]         row;
  logic [addr_width-1:0] row_a;
  logic                  col_ok;
  logic                  started;
  logic                  in_win;
  logic                  hit;

  assign col_ok  = {1'b0, num_col} >= LANE_T;
  assign started = t >= LANE_T;
  // row wraps when t < LANE, but started masks that case
  assign row     = t - LANE_T;
  assign in_win  = row <= {1'b0, num_row};
  assign hit     = en & col_ok & started & in_win;
  assign row_a   = addr_width'(row);

  assign wr_en   = hit;
  assign wr_addr = hit ? base_addr + row_a : '0;

endmodule

// File: rtl/master_write_control.sv
// Writer FSM: drains a skewed (diagonal) systolic result tile into
// per-lane memory ports. Ports: clk/reset, active start pulse,
// base_addr/num_row/num_col tile params, wr_addr/wr_en lanes,
// busy/done status. All outputs are registered.
module master_write_control
  import master_write_control_pkg::*;
#(
  parameter int addr_width   = TPU_ADDR_WIDTH,
  parameter int width_height = TPU_WIDTH_HEIGHT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                active,
  input  logic [addr_width-1:0]               base_addr,
  input  logic [$clog2(width_height)-1:0]     num_row,
  input  logic [$clog2(width_height)-1:0]     num_col,
  output logic [addr_width*width_height-1:0]  wr_addr,
  output logic [width_height-1:0]             wr_en,
  output logic                                busy,
  output logic                                done
);

  localparam int CW = $clog2(width_height);
  localparam int TW = CW + 1;
  localparam int AL = addr_width * width_height;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          t_q, t_d;
  logic [addr_width-1:0]  base_q, base_d;
  logic [CW-1:0]          nrow_q, nrow_d;
  logic [CW-1:0]          ncol_q, ncol_d;
  logic [TW-1:0]          last_t;

  logic [width_height-1:0] wr_en_q, wr_en_d;
  logic [AL-1:0]           wr_addr_q, wr_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    lane_go;

  assign last_t = TW'(last_step(32'(nrow_q), 32'(ncol_q)));

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    base_d  = base_q;
    nrow_d  = nrow_q;
    ncol_d  = ncol_q;
    unique case (state_q)
      S_IDLE: begin
        if (active) begin
          state_d = S_WRITE;
          t_d     = '0;
          base_d  = base_addr;
          nrow_d  = num_row;
          ncol_d  = num_col;
        end
      end
      S_WRITE: begin
        if (t_q == last_t) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Lane outputs are computed from next-state values so the
  // registered wr_en appears the cycle right after active.
  assign lane_go = (state_d == S_WRITE);
  assign busy_d  = (state_d != S_IDLE);
  assign done_d  = (state_d == S_DONE);

  for (genvar c = 0; c < width_height; c++) begin : g_lane
    write_lane #(
      .LANE       (c),
      .addr_width (addr_width),
      .cnt_width  (CW)
    ) u_lane (
      .en        (lane_go),
      .t         (t_d),
      .num_row   (nrow_d),
      .num_col   (ncol_d),
      .base_addr (base_d),
      .wr_en     (wr_en_d[c]),
      .wr_addr   (wr_addr_d[c*addr_width +: addr_width])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      base_q    <= '0;
      nrow_q    <= '0;
      ncol_q    <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      base_q    <= base_d;
      nrow_q    <= nrow_d;
      ncol_q    <= ncol_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_master_write_control.sv
// Testbench for master_write_control: directed and random tiles
// checked against a row/column tile model with immediate asserts.
module tb_master_write_control;

  localparam int AW = 8;
  localparam int WH = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            active;
  logic [AW-1:0]   base_addr;
  logic [3:0]      num_row;
  logic [3:0]      num_col;
  logic [AW*WH-1:0] wr_addr;
  logic [WH-1:0]   wr_en;
  logic            busy;
  logic            done;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  master_write_control #(
    .addr_width   (AW),
    .width_height (WH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .base_addr (base_addr),
    .num_row   (num_row),
    .num_col   (num_col),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: element (r,c) of the tile leaves the array at step r+c
  // on lane c and lands at base + r.
  task automatic run_seq(input logic [7:0] b, input int nr,
                         input int nc, input bit hold);
    logic [WH-1:0]    en_e [0:30];
    logic [AW*WH-1:0] ad_e [0:30];
    bit               seen [0:15][0:15];
    int               steps;
    int               nwr;
    int               dup;
    logic [7:0]       rr;
    steps = nr + nc + 1;
    nwr = 0;
    dup = 0;
    for (int k = 0; k < 31; k++) begin
      en_e[k] = '0;
      ad_e[k] = '0;
    end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        seen[r][c] = 1'b0;
    for (int r = 0; r <= nr; r++)
      for (int c = 0; c <= nc; c++) begin
        en_e[r+c][c] = 1'b1;
        ad_e[r+c][c*AW +: AW] = b + 8'(r);
      end
    base_addr = b;
    num_row   = 4'(nr);
    num_col   = 4'(nc);
    active    = 1'b1;
    step();
    if (!hold) active = 1'b0;
    for (int k = 0; k < steps; k++) begin
      chk($sformatf("wr_en t=%0d", k), 128'(wr_en), 128'(en_e[k]));
      chk($sformatf("wr_addr t=%0d", k), wr_addr, ad_e[k]);
      chk($sformatf("busy t=%0d", k), 128'(busy), 128'(1));
      chk($sformatf("done t=%0d", k), 128'(done), 128'(0));
      for (int c = 0; c < WH; c++) begin
        if (wr_en[c]) begin
          nwr++;
          rr = wr_addr[c*AW +: AW] - b;
          if (rr < 8'd16) begin
            if (seen[rr[3:0]][c]) dup++;
            seen[rr[3:0]][c] = 1'b1;
          end else begin
            dup++;
          end
        end
      end
      if (hold) begin
        base_addr = 8'($urandom);
        num_row   = 4'($urandom);
        num_col   = 4'($urandom);
      end
      step();
    end
    chk("done pulse", 128'(done), 128'(1));
    chk("done wr_en", 128'(wr_en), 128'(0));
    chk("done wr_addr", wr_addr, 128'(0));
    chk("done busy", 128'(busy), 128'(1));
    step();
    chk("idle done", 128'(done), 128'(0));
    chk("idle busy", 128'(busy), 128'(0));
    chk("idle wr_en", 128'(wr_en), 128'(0));
    chk("write count", 128'(nwr), 128'((nr + 1) * (nc + 1)));
    chk("duplicates", 128'(dup), 128'(0));
  endtask

  initial begin
    reset     = 1'b1;
    active    = 1'b0;
    base_addr = '0;
    num_row   = '0;
    num_col   = '0;
    step();
    step();
    chk("rst wr_en", 128'(wr_en), 128'(0));
    chk("rst wr_addr", wr_addr, 128'(0));
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst done", 128'(done), 128'(0));
    reset = 1'b0;
    step();
    chk("post rst busy", 128'(busy), 128'(0));

    run_seq(8'h10, 0, 0, 1'b0);
    run_seq(8'h20, 3, 2, 1'b0);
    run_seq(8'hFE, 3, 0, 1'b0);
    run_seq(8'h80, 15, 15, 1'b0);

    // abort at t=3 of a 4x3 tile
    base_addr = 8'h20;
    num_row   = 4'd3;
    num_col   = 4'd2;
    active    = 1'b1;
    step();
    active = 1'b0;
    step();
    step();
    step();
    chk("abort t3 wr_en", 128'(wr_en), 128'(16'h0007));
    chk("abort t3 addr", 128'(wr_addr[23:0]), 128'(24'h212223));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort wr_en", 128'(wr_en), 128'(0));
    chk("abort wr_addr", wr_addr, 128'(0));
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort done", 128'(done), 128'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort no done", 128'(done), 128'(0));
      chk("abort idle", 128'(busy), 128'(0));
    end
    run_seq(8'h20, 3, 2, 1'b0);

    // active held high: params scrambled mid-sequence are ignored,
    // the next tile only starts from IDLE after DONE
    run_seq(8'h40, 2, 5, 1'b1);
    run_seq(8'h55, 4, 1, 1'b1);
    active = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_seq(8'($urandom), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/master_write_control.md
MASTER_WRITE_CONTROL -- requirements
Module: master_write_control

Interface
REQ-001 SHALL have parameter addr_width, default 8, memory address width per lane.
REQ-002 SHALL have parameter width_height, default 16, systolic array dimension (lane count).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port active  input  1  one-cycle start request.
REQ-006 SHALL have port base_addr  input  addr_width  first write address, row 0.
REQ-007 SHALL have port num_row  input  clog2(width_height)  row count minus one.
REQ-008 SHALL have port num_col  input  clog2(width_height)  column count minus one.
REQ-009 SHALL have port wr_addr  output  addr_width*width_height  per-lane write address; lane c at bits [c*addr_width +: addr_width].
REQ-010 SHALL have port wr_en  output  width_height  per-lane write enable; bit c = lane c.
REQ-011 SHALL have port busy  output  1  high while a write sequence is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on sequence completion.

Function
REQ-013 SHALL implement states IDLE, WRITE, DONE.
REQ-014 In IDLE, active=1 SHALL latch base_addr, num_row and num_col, clear step counter t to 0, and enter WRITE on the next edge.
REQ-015 active SHALL be ignored in WRITE and DONE; latched parameters SHALL NOT change mid-sequence.
REQ-016 In WRITE, lane c SHALL assert wr_en[c] iff c <= num_col and c <= t <= c + num_row (diagonal skew matching array output timing).
REQ-017 An enabled lane c SHALL drive wr_addr lane c = base_addr + (t - c), truncated modulo 2^addr_width (wrap permitted).
REQ-018 A disabled lane SHALL drive wr_addr lane = 0.
REQ-019 t SHALL be clog2(width_height)+1 bits wide, increment by 1 per WRITE cycle, and never overflow (max value 2*(width_height-1)).
REQ-020 WRITE SHALL last exactly num_row + num_col + 1 cycles; on t = num_row + num_col the FSM SHALL enter DONE.
REQ-021 DONE SHALL last one cycle with done=1, wr_en=0, then return to IDLE.
REQ-022 busy SHALL be 1 in WRITE and DONE, 0 in IDLE.
REQ-023 Latency: first wr_en assertion SHALL occur one cycle after the active cycle; an active in the same cycle as DONE SHALL be ignored, an active in the following IDLE cycle SHALL be accepted.
REQ-024 Total writes per sequence SHALL equal (num_row+1)*(num_col+1); each (row,col) address SHALL be written exactly once.
REQ-025 All outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-026 reset=1 SHALL force state IDLE, t=0, wr_en=0, wr_addr=0, busy=0, done=0 on the next edge.
REQ-027 reset SHALL take priority over active and SHALL abort a sequence mid-WRITE with no done pulse.

Structure
REQ-028 Default addr_width/width_height and the count-minus-one encoding of num_row/num_col SHALL live in the shared TPU package so reader and writer controllers agree.
REQ-029 FSM state encodings SHALL be local constants of this module.
REQ-030 A sub-module write_lane (window compare + address subtract for one lane, parameterised by lane index) SHALL be generated width_height times.

Verification
REQ-031 base_addr=0x10, num_row=0, num_col=0, active pulse -> one cycle wr_en=0x0001, lane0 addr 0x10; done next cycle.
REQ-032 base_addr=0x20, num_row=3, num_col=2 -> 6 WRITE cycles; t=0 wr_en=0x0001; t=2 wr_en=0x0007 addrs lane0/1/2 = 0x22/0x21/0x20; t=5 wr_en=0x0004 lane2 addr 0x23; 12 writes total.
REQ-033 base_addr=0xFE, num_row=3, num_col=0 -> lane0 addresses 0xFE,0xFF,0x00,0x01.
REQ-034 num_row=15, num_col=15 -> 31 WRITE cycles, 256 unique writes, t reaches 30 without overflow, single done pulse.
REQ-035 reset asserted at t=3 of REQ-032 sequence -> next cycle wr_en=0, busy=0, no done; fresh active then runs full sequence.
REQ-036 active held high through a sequence -> parameter changes ignored; new sequence begins only after DONE, from IDLE.
